// File: rtl/mux_arb.sv
// mux_arb: registered M:1 arbitrating mux with valid/ready on every channel.
// Define MUX_ARB_RR_EN for round-robin grant; otherwise fixed priority (lowest index wins).
module mux_arb #(
  parameter int N = 8,
  parameter int M = 4,
  localparam int IW = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [M*N-1:0]  d,
  input  logic [M-1:0]    valid_i,
  output logic [M-1:0]    ready_o,
  output logic [N-1:0]    y,
  output logic [IW-1:0]   sel_o,
  output logic            valid_o,
  input  logic            ready_i
);
  logic          load;
  logic          gv;
  logic [IW-1:0] g;
  logic [IW-1:0] idx;
  logic [N-1:0]  gd;
  logic [N-1:0]  ch [M];
  assign load = ~valid_o | ready_i;
  genvar i;
  for (i = 0; i < M; i++) begin : g_ch
    assign ch[i]      = d[i*N +: N];
    assign ready_o[i] = load & gv & (g == IW'(i));
  end
`ifdef MUX_ARB_RR_EN
  logic [IW-1:0] ptr;
  // Scan downward so the nearest index after ptr is the last (winning) assignment.
  always_comb begin
    g   = '0;
    gv  = 1'b0;
    gd  = '0;
    idx = '0;
    for (int k = M; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % M);
      if (valid_i[idx]) begin
        g  = idx;
        gv = 1'b1;
        gd = ch[idx];
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= IW'(M - 1);
    else if (load & gv) ptr <= g;
`else
  always_comb begin
    g   = '0;
    gv  = 1'b0;
    gd  = '0;
    idx = '0;
    for (int k = M - 1; k >= 0; k--) begin
      idx = IW'(k);
      if (valid_i[idx]) begin
        g  = idx;
        gv = 1'b1;
        gd = ch[idx];
      end
    end
  end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_o <= 1'b0;
      y       <= '0;
      sel_o   <= '0;
    end else if (load) begin
      valid_o <= gv;
      if (gv) begin
        y     <= gd;
        sel_o <= g;
      end
    end
endmodule
